hamming_mem_engine: RTL and testbench
=====================================

HAMMING_MEM_ENGINE -- requirements
Module: hamming_mem_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- NUM_MSG, 15, number of messages per run (1..127).
- SRC_BASE, 0, byte address of first source byte.
- DST_BASE, 30, byte address of first result byte.
- AW, 8, memory address width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, run request.
- mode, in, 1, operation select: 0 = encode, 1 = decode/correct.
- busy, out, 1, run in progress.
- done, out, 1, run complete.
- mem_addr, out, AW, byte address to data memory.
- mem_rd_data, in, 8, combinational read data for mem_addr.
- mem_wr_en, out, 1, write strobe; memory writes on the clk edge.
- mem_wr_data, out, 8, write data.
- sec_count, out, 8, single-error-corrected message count.
- ded_count, out, 8, double-error-detected message count.

Function
REQ-003 SHALL store message i (0-based) as two bytes: low byte at base+2i, high byte at base+2i+1. Address arithmetic is modulo 2^AW.
REQ-004 Encode source format SHALL be: high byte = {5'b0, d[11:9]}, low byte = d[8:1].
REQ-005 Encode result SHALL be the 16-bit word {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}, with:
- p8 = ^d[11:5]
- p4 = ^d[11:8] ^ ^d[4:2]
- p2 = d11^d10^d7^d6^d4^d3^d1
- p1 = d11^d9^d7^d5^d4^d2^d1
- p0 = XOR of d[11:1], p8, p4, p2, p1
REQ-006 Decode input SHALL be the 16-bit word in REQ-005 layout, where bit index k = Hamming position k.
- Syndrome s = XOR of indices k (1..15) of all set bits.
- P = XOR of all 16 bits.
REQ-007 Decode classification SHALL be:
- s==0 and P==0: F=00, no error.
- P==1: F=01; flip bit s, which is p0 when s==0; then increment sec_count.
- s!=0 and P==0: F=10; data uncorrected; increment ded_count.
REQ-008 Decode result SHALL be: high byte = {F[1:0], 3'b000, d[11:9]}, low byte = d[8:1].
REQ-009 SHALL implement state machine IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE; one state per cycle, 4 cycles per message:
- RD_LO latches low source byte.
- RD_HI latches high source byte.
- WR_LO writes low result byte to DST_BASE+2i.
- WR_HI writes high result byte to DST_BASE+2i+1 and increments i.
- From WR_HI: go to RD_LO if i<NUM_MSG, else DONE.
REQ-010 start SHALL be accepted only in IDLE or DONE; on accept:
- next state = RD_LO; i=0.
- mode latched.
- sec_count and ded_count cleared.
- done deasserted.
REQ-011 start and mode changes while busy SHALL be ignored; the latched mode governs the whole run.
REQ-012 busy SHALL be high in RD_LO through WR_HI.
REQ-013 done SHALL be high in DONE and hold until the next accepted start or reset.
REQ-014 Timing: with start accepted at edge 0, done SHALL first be high after edge 4*NUM_MSG+1.
REQ-015 mem_wr_en SHALL be high only in WR_LO/WR_HI; exactly 2*NUM_MSG writes per run.
REQ-016 In encode mode, sec_count and ded_count SHALL remain 0.
REQ-017 sec_count and ded_count SHALL saturate at 255.
REQ-018 mem_addr SHALL be SRC_BASE+2i in RD_LO, +1 in RD_HI; DST_BASE+2i / +1 in WR_LO/WR_HI; 0 in IDLE/DONE.

Reset
REQ-019 On reset SHALL go to IDLE; busy, done, mem_wr_en, sec_count, ded_count, mem_addr, mem_wr_data, i all 0.
REQ-020 Reset mid-run SHALL abort with no further writes; bytes already written are left as is.
REQ-021 reset SHALL take priority over simultaneous start.

Verification
REQ-022 Encode, 15 messages of d=11'b01010101010 (bytes 0xAA low, 0x02 high) -> each destination pair low 0xA5, high 0x55; done after cycle 61; counts 0.
REQ-023 Decode 0x55A5 -> low 0xAA, high 0x02; sec=0, ded=0.
REQ-024 Decode 0x57A5 (bit 9 flipped) -> low 0xAA, high 0x42; sec=1. Decode 0x55A4 (p0 flipped) -> same bytes, sec=1.
REQ-025 Decode 0x55A6 (bits 0,1 flipped) -> low 0xAA, high 0x82; ded=1.
REQ-026 Reset asserted 10 cycles into a run -> next cycle busy=0, mem_wr_en=0, done=0; no writes afterward. Start pulsed while busy -> ignored.
REQ-027 NUM_MSG=1: start -> exactly 2 writes; done high after edge 5. Restart from DONE clears counts.

Source files
------------

// File: rtl/hamming_mem_engine.sv
// Memory-to-memory SECDED Hamming engine: walks NUM_MSG two-byte messages,
// either encoding 11 data bits into a 16-bit codeword or decoding/correcting one.
module hamming_mem_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [7:0]    sec_count,
  output logic [7:0]    ded_count
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q;
  logic [7:0]  idx_next;
  logic        mode_q;
  logic [7:0]  lo_q, hi_q;
  logic        done_q;
  logic [7:0]  sec_q, ded_q;
  logic        accept;
  logic [AW-1:0] msg_off;

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign idx_next = {1'b0, idx_q} + 8'd1;
  assign msg_off  = AW'({idx_q, 1'b0});

  // Encode datapath: source bytes carry d[11:1] right-aligned.
  logic [11:1] d;
  logic        p8, p4, p2, p1, p0;
  logic [15:0] enc_word;

  assign d        = {hi_q[2:0], lo_q};
  assign p8       = ^d[11:5];
  assign p4       = (^d[11:8]) ^ (^d[4:2]);
  assign p2       = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1       = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0       = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
  assign enc_word = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

  // Decode datapath: bit index of the raw word is its Hamming position.
  logic [15:0] raw_word;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  flag;
  logic [11:1] dec_d;

  assign raw_word = {hi_q, lo_q};

  function automatic logic [3:0] data_pos(input int b);
    if (b == 1)      return 4'd3;
    else if (b <= 4) return 4'(b + 3);
    else             return 4'(b + 4);
  endfunction

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (raw_word[k]) syn = syn ^ 4'(k);
    end
    par  = ^raw_word;
    flag = 2'b00;
    if (par)              flag = 2'b01;
    else if (syn != 4'd0) flag = 2'b10;
    // Only data positions matter; a flip aimed at a check bit leaves data intact.
    dec_d = '0;
    for (int b = 1; b < 12; b++) begin
      dec_d[b] = raw_word[data_pos(b)] ^ (par && (syn == data_pos(b)));
    end
  end

  logic [7:0] res_lo, res_hi;
  assign res_lo = mode_q ? dec_d[8:1] : enc_word[7:0];
  assign res_hi = mode_q ? {flag, 3'b000, dec_d[11:9]} : enc_word[15:8];

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      IDLE, DONE: if (accept) state_d = RD_LO;
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = AW'(SRC_BASE) + msg_off;
        state_d  = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = AW'(SRC_BASE) + msg_off + AW'(1);
        state_d  = WR_LO;
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_addr    = AW'(DST_BASE) + msg_off;
        mem_wr_en   = !reset;
        mem_wr_data = res_lo;
        state_d     = WR_HI;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_addr    = AW'(DST_BASE) + msg_off + AW'(1);
        mem_wr_en   = !reset;
        mem_wr_data = res_hi;
        state_d     = (idx_next < 8'(NUM_MSG)) ? RD_LO : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done is a flag raised from the DONE state and held until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      sec_q   <= '0;
      ded_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q  <= '0;
        mode_q <= mode;
        sec_q  <= '0;
        ded_q  <= '0;
        done_q <= 1'b0;
      end else if (state_q == DONE) begin
        done_q <= 1'b1;
      end
      case (state_q)
        RD_LO: lo_q <= mem_rd_data;
        RD_HI: hi_q <= mem_rd_data;
        WR_HI: begin
          idx_q <= idx_q + 7'd1;
          if (mode_q && (flag == 2'b01) && (sec_q != 8'hFF)) sec_q <= sec_q + 8'd1;
          if (mode_q && (flag == 2'b10) && (ded_q != 8'hFF)) ded_q <= ded_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign sec_count = sec_q;
  assign ded_count = ded_q;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Bench for hamming_mem_engine: two instances (15-message default and a
// single-message instance whose destination wraps the address space).
module tb_hamming_mem_engine;

  localparam int N0   = 15;
  localparam int SRC0 = 0;
  localparam int DST0 = 30;
  localparam int N1   = 1;
  localparam int SRC1 = 100;
  localparam int DST1 = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, mode, busy, done, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data, sec_count, ded_count;
  logic       start1, mode1, busy1, done1, mem_wr_en1;
  logic [7:0] mem_addr1, mem_rd_data1, mem_wr_data1, sec_count1, ded_count1;

  logic [7:0] src0 [256];
  logic [7:0] src1 [256];

  assign mem_rd_data  = src0[mem_addr];
  assign mem_rd_data1 = src1[mem_addr1];

  hamming_mem_engine #(.NUM_MSG(N0), .SRC_BASE(SRC0), .DST_BASE(DST0), .AW(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .sec_count(sec_count), .ded_count(ded_count)
  );

  hamming_mem_engine #(.NUM_MSG(N1), .SRC_BASE(SRC1), .DST_BASE(DST1), .AW(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
    .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1), .mem_wr_en(mem_wr_en1),
    .mem_wr_data(mem_wr_data1), .sec_count(sec_count1), .ded_count(ded_count1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model: positional Hamming construction, nearest-codeword decode
  function automatic logic [15:0] model_enc(input logic [10:0] dv);
    logic [15:0] w;
    logic        p;
    int          j;
    w = '0;
    j = 0;
    for (int pos = 3; pos < 16; pos++) begin
      if (pos != 4 && pos != 8) begin
        w[pos] = dv[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if (((pos >> b) & 1) == 1 && pos != (1 << b)) p = p ^ w[pos];
      end
      w[1 << b] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] model_data(input logic [15:0] w);
    logic [10:0] dv;
    int          j;
    dv = '0;
    j  = 0;
    for (int pos = 3; pos < 16; pos++) begin
      if (pos != 4 && pos != 8) begin
        dv[j] = w[pos];
        j++;
      end
    end
    return dv;
  endfunction

  function automatic logic [15:0] model_dec(input logic [15:0] w);
    logic [1:0]  f;
    logic [10:0] dv;
    logic [15:0] wc;
    dv = model_data(w);
    if (model_enc(dv) == w) f = 2'b00;
    else begin
      f = 2'b10;
      for (int j = 0; j < 16; j++) begin
        wc = w ^ (16'd1 << j);
        if (model_enc(model_data(wc)) == wc) begin
          f  = 2'b01;
          dv = model_data(wc);
        end
      end
    end
    return {f, 3'b000, dv[10:8], dv[7:0]};
  endfunction

  // scoreboard: expected writes as {addr, data}
  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] e0, e1;
  int          wr_cnt  = 0;
  int          wr1_cnt = 0;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() > 0) begin
        e0 = exp_q.pop_front();
        check("wr0", {16'd0, mem_addr, mem_wr_data}, {16'd0, e0});
      end
    end
    if (mem_wr_en1 === 1'b1) begin
      wr1_cnt++;
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        check("wr1", {16'd0, mem_addr1, mem_wr_data1}, {16'd0, e1});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which, input bit m);
    tick();
    if (which) begin start1 = 1'b1; mode1 = m; end
    else       begin start  = 1'b1; mode  = m; end
    tick();
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    int n;
    n = 0;
    while (!(which ? done1 : done) && n < budget) begin
      tick();
      n++;
    end
    check(which ? "done1_wait" : "done0_wait", {31'd0, which ? done1 : done}, 32'd1);
  endtask

  logic [15:0] w, r;
  logic [10:0] dv;
  int          base_cnt, exp_sec, exp_ded, j1, j2;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; start1 = 1'b0; mode1 = 1'b0;
    for (int a = 0; a < 256; a++) begin
      src0[a] = 8'h00;
      src1[a] = 8'h00;
    end
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    check("rst_sec", {24'd0, sec_count}, 32'd0);
    check("rst_ded", {24'd0, ded_count}, 32'd0);
    reset = 1'b0;

    // encode 15 copies of d = 11'b01010101010; start/mode pulsed mid-run
    for (int i = 0; i < N0; i++) begin
      src0[SRC0 + 2*i]     = 8'hAA;
      src0[SRC0 + 2*i + 1] = 8'h02;
      exp_q.push_back({8'(DST0 + 2*i), 8'hA5});
      exp_q.push_back({8'(DST0 + 2*i + 1), 8'h55});
    end
    base_cnt = wr_cnt;
    pulse_start(1'b0, 1'b0);
    check("enc_busy", {31'd0, busy}, 32'd1);
    check("enc_rd_addr", {24'd0, mem_addr}, SRC0);
    for (int k = 1; k <= 4*N0; k++) begin
      tick();
      if (k == 5)      begin start = 1'b1; mode = 1'b1; end
      else if (k == 6) begin start = 1'b0; mode = 1'b0; end
    end
    check("enc_done_early", {31'd0, done}, 32'd0);
    tick();
    check("enc_done", {31'd0, done}, 32'd1);
    check("enc_idle_addr", {24'd0, mem_addr}, 32'd0);
    check("enc_wr_count", wr_cnt - base_cnt, 2*N0);
    check("enc_q_empty", exp_q.size(), 32'd0);
    check("enc_sec", {24'd0, sec_count}, 32'd0);
    check("enc_ded", {24'd0, ded_count}, 32'd0);

    // decode: fixed words with literal results, then random 0/1/2-bit errors
    exp_sec = 0;
    exp_ded = 0;
    for (int i = 0; i < N0; i++) begin
      case (i)
        0: w = 16'h55A5;
        1: w = 16'h57A5;
        2: w = 16'h55A4;
        3: w = 16'h55A6;
        default: begin
          dv = 11'($urandom_range(0, 2047));
          w  = model_enc(dv);
          j1 = $urandom_range(0, 15);
          j2 = (j1 + $urandom_range(1, 15)) % 16;
          if (i % 3 >= 1) w = w ^ (16'd1 << j1);
          if (i % 3 == 2) w = w ^ (16'd1 << j2);
        end
      endcase
      src0[SRC0 + 2*i]     = w[7:0];
      src0[SRC0 + 2*i + 1] = w[15:8];
      case (i)
        0: r = 16'h02AA;
        1: r = 16'h42AA;
        2: r = 16'h42AA;
        3: r = 16'h82AA;
        default: r = model_dec(w);
      endcase
      if (r[15:14] == 2'b01) exp_sec++;
      if (r[15:14] == 2'b10) exp_ded++;
      exp_q.push_back({8'(DST0 + 2*i), r[7:0]});
      exp_q.push_back({8'(DST0 + 2*i + 1), r[15:8]});
    end
    base_cnt = wr_cnt;
    pulse_start(1'b0, 1'b1);
    wait_done(1'b0, 4*N0 + 10);
    check("dec_wr_count", wr_cnt - base_cnt, 2*N0);
    check("dec_q_empty", exp_q.size(), 32'd0);
    check("dec_sec", {24'd0, sec_count}, exp_sec);
    check("dec_ded", {24'd0, ded_count}, exp_ded);

    // reset 10 cycles into a run, with start held high alongside it
    pulse_start(1'b0, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    start = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr", {24'd0, mem_addr}, 32'd0);
    base_cnt = wr_cnt;
    repeat (20) tick();
    check("abort_no_writes", wr_cnt - base_cnt, 32'd0);
    check("abort_still_idle", {31'd0, busy}, 32'd0);

    // single message, destination wraps 255 -> 0, one correctable error
    dv = 11'($urandom_range(0, 2047));
    w  = model_enc(dv) ^ (16'd1 << $urandom_range(0, 15));
    src1[SRC1]     = w[7:0];
    src1[SRC1 + 1] = w[15:8];
    r = model_dec(w);
    exp1_q.push_back({8'd255, r[7:0]});
    exp1_q.push_back({8'd0, r[15:8]});
    base_cnt = wr1_cnt;
    pulse_start(1'b1, 1'b1);
    repeat (4) tick();
    check("n1_done_early", {31'd0, done1}, 32'd0);
    tick();
    check("n1_done", {31'd0, done1}, 32'd1);
    check("n1_wr_count", wr1_cnt - base_cnt, 32'd2);
    check("n1_q_empty", exp1_q.size(), 32'd0);
    check("n1_sec", {24'd0, sec_count1}, 32'd1);
    check("n1_ded", {24'd0, ded_count1}, 32'd0);

    // restart from DONE in encode mode clears counts and done
    dv = 11'($urandom_range(0, 2047));
    src1[SRC1]     = dv[7:0];
    src1[SRC1 + 1] = {5'b0, dv[10:8]};
    r = model_enc(dv);
    exp1_q.push_back({8'd255, r[7:0]});
    exp1_q.push_back({8'd0, r[15:8]});
    base_cnt = wr1_cnt;
    pulse_start(1'b1, 1'b0);
    check("restart_sec", {24'd0, sec_count1}, 32'd0);
    check("restart_done", {31'd0, done1}, 32'd0);
    check("restart_busy", {31'd0, busy1}, 32'd1);
    wait_done(1'b1, 20);
    check("restart_wr_count", wr1_cnt - base_cnt, 32'd2);
    check("restart_q_empty", exp1_q.size(), 32'd0);
    check("restart_ded", {24'd0, ded_count1}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
